// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
//   mode_e  : 3-bit operation code carried by cmd_mode
//   state_e : control FSM states
//   is_shift_mode() : true for the five modes that move bits
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
//   mode_i        : operation to apply
//   data_i        : current register value
//   serial_in_l_i : bit entering the LSB on SHL
//   serial_in_r_i : bit entering the MSB on SHR
//   data_o        : register value after one step
//   bit_out_o     : bit leaving the register (wrapped bit for rotates)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e              mode_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               serial_in_l_i,
  input  logic               serial_in_r_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               bit_out_o
);

  always_comb begin
    data_o    = data_i;
    bit_out_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        data_o    = {data_i[WIDTH-2:0], serial_in_l_i};
        bit_out_o = data_i[WIDTH-1];
      end
      MODE_SHR: begin
        data_o    = {serial_in_r_i, data_i[WIDTH-1:1]};
        bit_out_o = data_i[0];
      end
      MODE_ROL: begin
        data_o    = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        bit_out_o = data_i[WIDTH-1];
      end
      MODE_ROR: begin
        data_o    = {data_i[0], data_i[WIDTH-1:1]};
        bit_out_o = data_i[0];
      end
      MODE_ASR: begin
        // Sign bit is replicated, so long counts settle at all-sign.
        data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        bit_out_o = data_i[0];
      end
      default: begin
        data_o    = data_i;
        bit_out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Command-driven universal shift register.
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid / cmd_ready : command handshake (ready only when idle)
//   cmd_mode, cmd_count   : operation and number of single-bit shifts
//   load_data             : parallel load value
//   serial_in_l/_r        : serial bits for SHL / SHR, sampled per shift edge
//   data_out, serial_out  : register contents, last bit shifted out
//   busy, done            : command in progress, one-cycle completion pulse
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;

  mode_e            cmd_mode_e;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  assign cmd_mode_e = mode_e'(cmd_mode);

  // The step always works on the captured mode, never the live input.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode_i        (mode_q),
    .data_i        (data_q),
    .serial_in_l_i (serial_in_l),
    .serial_in_r_i (serial_in_r),
    .data_o        (step_data),
    .bit_out_o     (step_bit)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sout_d  = sout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d = cmd_mode_e;
          if (cmd_mode_e == MODE_LOAD) begin
            data_d = load_data;
          end
          if (is_shift_mode(cmd_mode_e) && (cmd_count != '0)) begin
            rem_d   = cmd_count;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        sout_d = step_bit;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign data_out   = data_q;
  assign serial_out = sout_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] load_data;
  logic             serial_in_l;
  logic             serial_in_r;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_count   (cmd_count),
    .load_data   (load_data),
    .serial_in_l (serial_in_l),
    .serial_in_r (serial_in_r),
    .data_out    (data_out),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       s;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending command (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_data", int'(data_out), int'(e.d));
        chk("done_sout", int'(serial_out), int'(e.s));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!cmd_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Issue one command; lat is the hand-computed number of edges from accept to done.
  task automatic do_cmd(input logic [2:0] mode, input int cnt, input logic [7:0] ld,
                        input logic sil, input logic sir,
                        input logic [7:0] exp_d, input logic exp_s, input int lat,
                        output int busy_cycles);
    exp_t e;
    int   t;
    @(negedge clk);
    wait_ready();
    cmd_mode    = mode;
    cmd_count   = CNT_W'(cnt);
    load_data   = ld;
    serial_in_l = sil;
    serial_in_r = sir;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    e.d  = exp_d;
    e.s  = exp_s;
    e.at = cyc + lat;
    exp_q.push_back(e);
    cmd_valid   = 1'b0;
    busy_cycles = 0;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      busy_cycles++;
      @(negedge clk);
      t++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  initial begin
    int   bc;
    int   acc;
    int   prev_e;
    int   t;
    exp_t e;
    logic [7:0] held_exp [3];

    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_mode    = 3'd0;
    cmd_count   = '0;
    load_data   = '0;
    serial_in_l = 1'b0;
    serial_in_r = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_data", int'(data_out), 0);
    chk("rst_sout", int'(serial_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    // LOAD then rotate left.
    do_cmd(3'd1, 0, 8'hA5, 0, 0, 8'hA5, 1'b0, 0, bc);
    chk("load_busy_cycles", bc, 1);
    do_cmd(3'd4, 3, 8'h00, 0, 0, 8'h2D, 1'b1, 3, bc);

    // Logical shift right with serial 1, then long ASR.
    do_cmd(3'd1, 0, 8'h81, 0, 0, 8'h81, 1'b1, 0, bc);
    do_cmd(3'd3, 1, 8'h00, 0, 1, 8'hC0, 1'b1, 1, bc);
    do_cmd(3'd6, 9, 8'h00, 0, 0, 8'hFF, 1'b1, 9, bc);

    // Full-width shift left.
    do_cmd(3'd1, 0, 8'h01, 0, 0, 8'h01, 1'b1, 0, bc);
    do_cmd(3'd2, 8, 8'h00, 0, 0, 8'h00, 1'b1, 8, bc);
    chk("shl8_busy_cycles", bc, 9);

    // Zero-count shift and reserved code leave data alone.
    do_cmd(3'd1, 0, 8'h3C, 0, 0, 8'h3C, 1'b1, 0, bc);
    do_cmd(3'd3, 0, 8'hFF, 1, 1, 8'h3C, 1'b1, 0, bc);
    do_cmd(3'd7, 5, 8'hFF, 1, 1, 8'h3C, 1'b1, 0, bc);

    // Rotate right.
    do_cmd(3'd1, 0, 8'h96, 0, 0, 8'h96, 1'b1, 0, bc);
    do_cmd(3'd5, 2, 8'h00, 0, 0, 8'hA5, 1'b1, 2, bc);

    // cmd_valid held high: SHL by 2 with serial 1.
    do_cmd(3'd1, 0, 8'h00, 0, 0, 8'h00, 1'b1, 0, bc);
    held_exp[0] = 8'h03;
    held_exp[1] = 8'h0F;
    held_exp[2] = 8'h3F;
    @(negedge clk);
    cmd_mode    = 3'd2;
    cmd_count   = CNT_W'(2);
    serial_in_l = 1'b1;
    cmd_valid   = 1'b1;
    acc    = 0;
    prev_e = 0;
    t      = 0;
    while (acc < 3 && t < 40) begin
      chk("ready_vs_busy", int'(cmd_ready), int'(!busy));
      if (cmd_ready) begin
        e.d  = held_exp[acc];
        e.s  = 1'b0;
        e.at = cyc + 1 + 2;
        exp_q.push_back(e);
        if (acc > 0) chk("accept_gap", cyc + 1 - prev_e, 4);
        prev_e = cyc + 1;
        acc++;
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("held_accepts", acc, 3);
    @(negedge clk);
    wait_ready();

    // Reset in the middle of a rotate: no done pulse may follow.
    do_cmd(3'd1, 0, 8'h0F, 0, 0, 8'h0F, 1'b0, 0, bc);
    @(negedge clk);
    cmd_mode  = 3'd4;
    cmd_count = CNT_W'(5);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rol_data", int'(data_out), 8'h3C);
    chk("mid_rol_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sout", int'(serial_out), 0);
    repeat (6) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the shift-count field.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_mode  input  3  operation code (REQ-013).
REQ-008 cmd_count  input  CNT_W  number of single-bit shifts.
REQ-009 load_data  input  WIDTH  parallel load value.
REQ-010 serial_in_l  input  1  bit entering the LSB on a shift-left.
REQ-011 serial_in_r  input  1  bit entering the MSB on a logical shift-right.
REQ-012 data_out [WIDTH], serial_out [1], busy [1], done [1]  outputs: register contents, last bit shifted out, command in progress, one-cycle completion pulse.

Function
REQ-013 Modes SHALL be: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR (MSB replicated); code 7 SHALL behave as HOLD.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE; cmd_ready = 1 only in IDLE; busy = 1 in SHIFT and DONE.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; the mode and count are captured at that edge.
REQ-016 LOAD: data_out SHALL take load_data at the accept edge; FSM -> DONE.
REQ-017 HOLD, code 7, or any shift mode with cmd_count = 0: data_out SHALL be unchanged; FSM -> DONE.
REQ-018 Shift mode with cmd_count = N > 0: FSM -> SHIFT with remaining = N; one shift SHALL occur at each of the next N edges; after the edge that makes remaining 0, FSM -> DONE.
REQ-019 serial_in_l and serial_in_r SHALL be sampled at each shift edge, not at the accept edge.
REQ-020 serial_out SHALL update at every shift edge to the bit that leaves the register: MSB for SHL/ROL, LSB for SHR/ROR/ASR. For rotates it is the wrapped bit. Otherwise it SHALL hold.
REQ-021 N > WIDTH SHALL be legal: rotates wrap modulo WIDTH; SHL/SHR keep shifting in serial inputs; ASR saturates to all-sign.
REQ-022 done SHALL be 1 exactly in the DONE cycle; DONE -> IDLE unconditionally at the next edge.
REQ-023 cmd_valid while cmd_ready = 0 SHALL be ignored, with no queuing.
REQ-024 Latency from accept edge k: LOAD/HOLD done in cycle after edge k; N-shift done after edge k+N; cmd_ready high again after edge k+N+1.

Reset
REQ-025 While reset = 1 at an edge: data_out = 0, serial_out = 0, done = 0, busy = 0, FSM = IDLE, remaining = 0.
REQ-026 Reset SHALL take priority over any command, including one in SHIFT or DONE; the in-flight command SHALL be discarded with no done pulse.
REQ-027 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 Package shift_pkg SHALL hold the mode enum (3-bit) and the FSM state enum.
REQ-029 One combinational sub-module, shift_step, SHALL compute the next register value and the outgoing bit for a given mode. Its inputs are the current register value, serial_in_l and serial_in_r. The top instantiates it once.

Verification (WIDTH=8)
REQ-030 Reset: assert reset mid-SHIFT (ROL, N=5, after 2 shifts) -> next cycle data_out=0x00, busy=0, cmd_ready=1, no done pulse.
REQ-031 LOAD 0xA5 then ROL N=3 -> data_out=0x2D, serial_out=1, done one cycle after the 3rd shift edge.
REQ-032 LOAD 0x81, SHR N=1 with serial_in_r=1 -> data_out=0xC0, serial_out=1; then ASR N=9 -> data_out=0xFF.
REQ-033 LOAD 0x01, SHL N=8 with serial_in_l=0 -> data_out=0x00, serial_out=1 (last bit out was the original LSB), busy high for 9 cycles.
REQ-034 Hold cmd_valid=1 continuously with SHL N=2 -> commands accepted only every 4th edge; no command is accepted while busy=1.
REQ-035 SHR N=0 and mode 7 on data 0x3C -> data_out stays 0x3C, done pulses in the cycle after accept, serial_out unchanged.
